// File: rtl/rp_adc_decim.sv
// Power-of-two decimator/averager for one ADC channel.
// Each window of 2^N valid samples yields either the window mean or its last sample.
module rp_adc_decim #(
  parameter int DW     = 14,
  parameter int SHW    = 5,
  parameter int SH_MAX = 16
) (
  input  logic           adc_clk_i,
  input  logic           adc_rst_i,
  input  logic [DW-1:0]  adc_dat_i,
  input  logic           adc_val_i,
  input  logic [SHW-1:0] cfg_dec_i,
  input  logic           cfg_avg_i,
  input  logic           cfg_sync_i,
  output logic [DW-1:0]  dec_dat_o,
  output logic           dec_val_o
);

  localparam int AW = DW + SH_MAX;

  logic signed [AW-1:0] acc_q, acc_d;
  logic [SH_MAX-1:0]    cnt_q, cnt_d;
  logic [SHW-1:0]       cfg_dec_q, cfg_dec_d;
  logic [DW-1:0]        dat_q, dat_d;
  logic                 val_q, val_d;

  logic [SHW-1:0]       n_clamp;
  logic [SH_MAX-1:0]    last_idx;
  logic signed [AW-1:0] x_ext;
  logic signed [AW-1:0] sum;
  logic                 restart;
  logic                 win_end;

  always_comb begin
    n_clamp  = (cfg_dec_i > SHW'(SH_MAX)) ? SHW'(SH_MAX) : cfg_dec_i;
    restart  = cfg_sync_i || (n_clamp != cfg_dec_q);
    // 2^N - 1 as a mask; shifting a full word by SH_MAX yields 0, so N=SH_MAX gives all ones
    last_idx = ~({SH_MAX{1'b1}} << cfg_dec_q);
    win_end  = (cnt_q == last_idx);
    x_ext    = {{SH_MAX{adc_dat_i[DW-1]}}, adc_dat_i};
    sum      = acc_q + x_ext;
  end

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    cfg_dec_d = cfg_dec_q;
    dat_d     = dat_q;
    val_d     = 1'b0;
    if (restart) begin
      acc_d     = '0;
      cnt_d     = '0;
      cfg_dec_d = n_clamp;
    end else if (adc_val_i) begin
      if (win_end) begin
        // Mean fits DW bits after the shift, so truncation only drops sign copies
        dat_d = cfg_avg_i ? DW'(sum >>> cfg_dec_q) : adc_dat_i;
        val_d = 1'b1;
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + SH_MAX'(1);
      end
    end
  end

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      cfg_dec_q <= '0;
      dat_q     <= '0;
      val_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      cfg_dec_q <= cfg_dec_d;
      dat_q     <= dat_d;
      val_q     <= val_d;
    end
  end

  assign dec_dat_o = dat_q;
  assign dec_val_o = val_q;

endmodule

// File: tb/tb_rp_adc_decim.sv
// Bench for rp_adc_decim: directed vector table, hand sequences and a random run,
// all checked against a window-list reference model.
module tb_rp_adc_decim;

  logic        adc_clk_i = 1'b0;
  logic        adc_rst_i;
  logic [13:0] adc_dat_i;
  logic        adc_val_i;
  logic [4:0]  cfg_dec_i;
  logic        cfg_avg_i;
  logic        cfg_sync_i;
  logic [13:0] dec_dat_o;
  logic        dec_val_o;

  rp_adc_decim dut (
    .adc_clk_i (adc_clk_i),
    .adc_rst_i (adc_rst_i),
    .adc_dat_i (adc_dat_i),
    .adc_val_i (adc_val_i),
    .cfg_dec_i (cfg_dec_i),
    .cfg_avg_i (cfg_avg_i),
    .cfg_sync_i(cfg_sync_i),
    .dec_dat_o (dec_dat_o),
    .dec_val_o (dec_val_o)
  );

  always #5 adc_clk_i = ~adc_clk_i;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: the current window is a list of samples
  int     m_cfg = 0;
  longint m_win[$];
  bit     m_val = 0;
  int     m_dat = 0;

  typedef struct {
    int dec; bit avg; bit sync; bit val; int dat;
    bit ev; int ed;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int floor_div(input longint s, input longint d);
    longint q;
    q = s / d;
    if ((s % d != 0) && (s < 0)) q = q - 1;
    return int'(q);
  endfunction

  function automatic void model(input int dec, input bit avg, input bit sync,
                                input bit val, input int dat, input bit rst);
    int n;
    longint s;
    if (rst) begin
      m_cfg = 0; m_win.delete(); m_val = 0; m_dat = 0;
      return;
    end
    n = (dec > 16) ? 16 : dec;
    if (sync || n != m_cfg) begin
      m_cfg = n; m_win.delete(); m_val = 0;
    end else if (!val) begin
      m_val = 0;
    end else begin
      m_win.push_back(longint'(dat));
      if (m_win.size() == (1 << n)) begin
        s = 0;
        foreach (m_win[i]) s += m_win[i];
        m_dat = avg ? floor_div(s, longint'(1) << n) : dat;
        m_val = 1;
        m_win.delete();
      end else begin
        m_val = 0;
      end
    end
  endfunction

  task automatic step(input int dec, input bit avg, input bit sync,
                      input bit val, input int dat, input bit rst);
    adc_rst_i  = rst;
    cfg_dec_i  = dec[4:0];
    cfg_avg_i  = avg;
    cfg_sync_i = sync;
    adc_val_i  = val;
    adc_dat_i  = dat[13:0];
    model(dec, avg, sync, val, dat, rst);
    @(posedge adc_clk_i);
    #1;
    check("model_val", int'(dec_val_o), int'(m_val));
    check("model_dat", int'($signed(dec_dat_o)), m_dat);
  endtask

  function automatic void add(input int dec, input bit avg, input bit sync,
                              input bit val, input int dat, input bit ev, input int ed);
    vec_t v;
    v.dec = dec; v.avg = avg; v.sync = sync; v.val = val; v.dat = dat;
    v.ev = ev; v.ed = ed;
    tbl.push_back(v);
  endfunction

  initial begin
    // N=0 pass-through
    add(0,1,0,1,5,    1,5);
    add(0,1,0,1,-3,   1,-3);
    add(0,1,0,1,8191, 1,8191);
    // N=2 averaging, including floor toward -inf
    add(2,1,0,0,0, 0,8191);
    add(2,1,0,1,1, 0,8191);
    add(2,1,0,1,2, 0,8191);
    add(2,1,0,1,3, 0,8191);
    add(2,1,0,1,6, 1,3);
    add(2,1,0,1,-1, 0,3);
    add(2,1,0,1,-1, 0,3);
    add(2,1,0,1,-1, 0,3);
    add(2,1,0,1,-2, 1,-2);
    // N=2 keep-last, then with valid gaps
    add(2,0,0,1,10, 0,-2);
    add(2,0,0,1,20, 0,-2);
    add(2,0,0,1,30, 0,-2);
    add(2,0,0,1,40, 1,40);
    add(2,0,0,1,11, 0,40);
    add(2,0,0,0,77, 0,40);
    add(2,0,0,1,21, 0,40);
    add(2,0,0,0,77, 0,40);
    add(2,0,0,1,31, 0,40);
    add(2,0,0,0,77, 0,40);
    add(2,0,0,0,77, 0,40);
    add(2,0,0,1,41, 1,41);
    // N=3 with sync after 5 samples
    add(3,1,0,0,0, 0,41);
    for (int i = 0; i < 5; i++) add(3,1,0,1,7, 0,41);
    add(3,1,1,1,999, 0,41);
    for (int i = 0; i < 7; i++) add(3,1,0,1,100, 0,41);
    add(3,1,0,1,100, 1,100);
    // exponent change 2->1 mid-window
    add(2,1,0,0,0, 0,100);
    add(2,1,0,1,4, 0,100);
    add(2,1,0,1,4, 0,100);
    add(1,1,0,1,50, 0,100);
    add(1,1,0,1,6, 0,100);
    add(1,1,0,1,8, 1,7);

    // reset state
    step(0,0,0,0,0,1);
    step(0,0,0,0,0,1);
    check("rst_val", int'(dec_val_o), 0);
    check("rst_dat", int'($signed(dec_dat_o)), 0);

    foreach (tbl[k]) begin
      step(tbl[k].dec, tbl[k].avg, tbl[k].sync, tbl[k].val, tbl[k].dat, 0);
      check($sformatf("vec%0d_val", k), int'(dec_val_o), int'(tbl[k].ev));
      check($sformatf("vec%0d_dat", k), int'($signed(dec_dat_o)), tbl[k].ed);
    end

    // reset mid-window drops the partial sum
    step(2,1,0,0,0,0);
    step(2,1,0,1,40,0);
    step(2,1,0,1,40,0);
    step(2,1,0,1,40,1);
    check("midrst_val", int'(dec_val_o), 0);
    check("midrst_dat", int'($signed(dec_dat_o)), 0);
    step(2,1,0,1,99,0);
    for (int i = 0; i < 3; i++) step(2,1,0,1,8,0);
    check("postrst_noval", int'(dec_val_o), 0);
    step(2,1,0,1,8,0);
    check("postrst_val", int'(dec_val_o), 1);
    check("postrst_dat", int'($signed(dec_dat_o)), 8);

    // full 65536 window at -8192; exponent 20 clamps to 16, so 20->16 is no restart
    step(20,1,0,0,0,0);
    for (int i = 0; i < 30000; i++) step(20,1,0,1,-8192,0);
    for (int i = 0; i < 35535; i++) step(16,1,0,1,-8192,0);
    check("big_noval", int'(dec_val_o), 0);
    step(16,1,0,1,-8192,0);
    check("big_val", int'(dec_val_o), 1);
    check("big_dat", int'($signed(dec_dat_o)), -8192);

    // random run
    begin
      int dec = 0;
      bit avg = 1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 149) == 0) dec = $urandom_range(0, 5);
        if ($urandom_range(0, 9) == 0) avg = ~avg;
        step(dec, avg, ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
             $urandom_range(0, 16383) - 8192, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
